// File: rtl/dmem_responder_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dmem_responder_pkg : RV32 memory-access size encodings, control and state |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package dmem_responder_pkg;

  localparam logic [1:0] MEM_SIZE_B = 2'b00;
  localparam logic [1:0] MEM_SIZE_H = 2'b01;
  localparam logic [1:0] MEM_SIZE_W = 2'b10;

  typedef struct packed {
    logic       MemRW;
    logic [1:0] MemSize;
    logic       MemUnsigned;
  } ctrl_t;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_WAIT = 2'd1,
    DMEM_RESP = 2'd2
  } dmem_state_t;

endpackage
`default_nettype wire

// File: rtl/dmem_lane_fmt.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dmem_lane_fmt : store byte-enable/replication and load lane extraction    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module dmem_lane_fmt
  import dmem_responder_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic [31:0] wdata,
  input  logic        load_unsigned,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_lane = rword[7:0];
      2'd1:    byte_lane = rword[15:8];
      2'd2:    byte_lane = rword[23:16];
      default: byte_lane = rword[31:24];
    endcase
    half_lane = addr_lo[1] ? rword[31:16] : rword[15:0];
  end

  // Invalid sizes produce no enables and a zero load value.
  always_comb begin
    be        = 4'b0000;
    wdata_rep = 32'h0;
    rdata_ext = 32'h0;
    case (size)
      MEM_SIZE_B: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{~load_unsigned & byte_lane[7]}}, byte_lane};
      end
      MEM_SIZE_H: begin
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {{16{~load_unsigned & half_lane[15]}}, half_lane};
      end
      MEM_SIZE_W: begin
        be        = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = rword;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dmem_responder : valid/ready data-memory slave with programmable wait     |
// | states, byte-lane stores, extended loads and fault reporting. Rev 1.0     |
// +--------------------------------------------------------------------------+
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  dmem_state_t state;
  logic [3:0]  cnt;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  size_q;
  logic        uns_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic        accept;
  logic        commit;
  logic        cur_we;
  logic        cur_uns;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [1:0]  cur_size;
  logic        err;
  logic [AW-1:0] idx;
  logic [3:0]  be;
  logic [31:0] wdata_rep;
  logic [31:0] rdata_ext;

  assign req_ready = (state == DMEM_IDLE);
  assign rsp_valid = (state == DMEM_RESP);
  assign accept    = req_valid && (state == DMEM_IDLE);

  // With no wait states the commit edge is the accept edge, so the live request is used.
  assign commit = (state == DMEM_IDLE) ? (accept && (WAIT_CYCLES == 0))
                                       : ((state == DMEM_WAIT) && (cnt == 4'd0));

  assign cur_we    = (state == DMEM_IDLE) ? req_we       : we_q;
  assign cur_uns   = (state == DMEM_IDLE) ? req_unsigned : uns_q;
  assign cur_addr  = (state == DMEM_IDLE) ? req_addr     : addr_q;
  assign cur_wdata = (state == DMEM_IDLE) ? req_wdata    : wdata_q;
  assign cur_size  = (state == DMEM_IDLE) ? req_size     : size_q;

  assign err = (cur_size == 2'b11)
             || ((cur_size == MEM_SIZE_H) && cur_addr[0])
             || ((cur_size == MEM_SIZE_W) && (cur_addr[1:0] != 2'b00))
             || (cur_addr[31:2] >= 30'(DEPTH_WORDS));

  assign idx = cur_addr[AW+1:2];

  dmem_lane_fmt u_lane_fmt (
    .addr_lo       (cur_addr[1:0]),
    .size          (cur_size),
    .wdata         (cur_wdata),
    .load_unsigned (cur_uns),
    .rword         (mem[idx]),
    .be            (be),
    .wdata_rep     (wdata_rep),
    .rdata_ext     (rdata_ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= DMEM_IDLE;
      cnt       <= 4'd0;
      we_q      <= 1'b0;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      size_q    <= 2'b00;
      uns_q     <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        DMEM_IDLE: begin
          if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            if (WAIT_CYCLES == 0) begin
              state <= DMEM_RESP;
            end else begin
              cnt   <= WAIT_LOAD;
              state <= DMEM_WAIT;
            end
          end
        end
        DMEM_WAIT: begin
          if (cnt == 4'd0) state <= DMEM_RESP;
          else             cnt   <= cnt - 4'd1;
        end
        DMEM_RESP: begin
          if (rsp_ready) state <= DMEM_IDLE;
        end
        default: state <= DMEM_IDLE;
      endcase

      if (commit) begin
        rsp_err   <= err;
        rsp_rdata <= (err || cur_we) ? 32'h0 : rdata_ext;
      end
    end
  end

  // Storage is intentionally unreset; a reset during WAIT never reaches a commit edge.
  always_ff @(posedge clk) begin
    if (commit && cur_we && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_dmem_responder : three responders (0, 1 and 3 wait states) checked     |
// | against a word-array reference model with random and directed traffic.   |
// +--------------------------------------------------------------------------+
module tb_dmem_responder;

  localparam int DEPTH = 64;
  localparam int NDUT  = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid    [NDUT];
  logic        req_ready    [NDUT];
  logic        req_we       [NDUT];
  logic [31:0] req_addr     [NDUT];
  logic [31:0] req_wdata    [NDUT];
  logic [1:0]  req_size     [NDUT];
  logic        req_unsigned [NDUT];
  logic        rsp_valid    [NDUT];
  logic        rsp_ready    [NDUT];
  logic [31:0] rsp_rdata    [NDUT];
  logic        rsp_err      [NDUT];

  logic [31:0] model_mem [NDUT][DEPTH];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    dmem_responder #(
      .DEPTH_WORDS (DEPTH),
      .WAIT_CYCLES ((g == 0) ? 0 : ((g == 1) ? 1 : 3))
    ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid[g]),
      .req_ready    (req_ready[g]),
      .req_we       (req_we[g]),
      .req_addr     (req_addr[g]),
      .req_wdata    (req_wdata[g]),
      .req_size     (req_size[g]),
      .req_unsigned (req_unsigned[g]),
      .rsp_valid    (rsp_valid[g]),
      .rsp_ready    (rsp_ready[g]),
      .rsp_rdata    (rsp_rdata[g]),
      .rsp_err      (rsp_err[g])
    );
  end

  function automatic int wait_of(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 1 : 3);
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference behaviour: a word array updated by masked arithmetic.
  task automatic model_access(input int d, input bit we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [1:0] size, input bit uns,
                              output logic [31:0] exp_rdata, output logic exp_err);
    int nbytes, sh, w;
    logic [31:0] mask, word, val;
    exp_rdata = 32'h0;
    exp_err = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) ||
              (size == 2'd2 && addr % 4 != 0) || ((addr >> 2) >= DEPTH);
    if (exp_err) return;
    w      = int'(addr >> 2);
    nbytes = 1 << size;
    sh     = 8 * int'(addr % 4);
    mask   = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
    word   = model_mem[d][w];
    if (we) begin
      model_mem[d][w] = (word & ~(mask << sh)) | ((wdata & mask) << sh);
    end else begin
      val = (word >> sh) & mask;
      if (!uns && nbytes < 4 && val[8*nbytes-1]) val = val | ~mask;
      exp_rdata = val;
    end
  endtask

  task automatic txn(input int d, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [1:0] size, input bit uns, input int hold, input string tag,
                     output logic [31:0] got);
    logic [31:0] exp_rdata;
    logic        exp_err;
    int n;
    model_access(d, we, addr, wdata, size, uns, exp_rdata, exp_err);
    got = 32'hx;
    @(negedge clk);
    req_we[d] = we; req_addr[d] = addr; req_wdata[d] = wdata;
    req_size[d] = size; req_unsigned[d] = uns; req_valid[d] = 1'b1;
    rsp_ready[d] = 1'b1;
    n = 0;
    while (!req_ready[d] && n < 20) begin @(negedge clk); n++; end
    if (!req_ready[d]) begin
      check_val({tag, "/ready_timeout"}, 32'd0, 32'd1);
      req_valid[d] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    // Garbage on the request bus after acceptance must not disturb the transaction.
    req_we[d] = 1'($urandom); req_addr[d] = $urandom; req_wdata[d] = $urandom;
    req_size[d] = 2'($urandom); req_unsigned[d] = 1'($urandom);
    n = 0;
    @(negedge clk);
    while (!rsp_valid[d] && n < 20) begin @(negedge clk); n++; end
    req_valid[d] = 1'b0;
    check_val({tag, "/latency"}, 32'(n), 32'(wait_of(d)));
    if (!rsp_valid[d]) begin
      rsp_ready[d] = 1'b1;
      return;
    end
    got = rsp_rdata[d];
    check_val({tag, "/rdata"}, rsp_rdata[d], exp_rdata);
    check_val({tag, "/err"}, 32'(rsp_err[d]), 32'(exp_err));
    if (hold > 0) begin
      rsp_ready[d] = 1'b0;
      repeat (hold) begin
        @(negedge clk);
        check_val({tag, "/hold_valid"}, 32'(rsp_valid[d]), 32'd1);
        check_val({tag, "/hold_rdata"}, rsp_rdata[d], exp_rdata);
        check_val({tag, "/hold_err"}, 32'(rsp_err[d]), 32'(exp_err));
        check_val({tag, "/hold_req_ready"}, 32'(req_ready[d]), 32'd0);
      end
      rsp_ready[d] = 1'b1;
    end
    @(negedge clk);
    check_val({tag, "/idle_valid"}, 32'(rsp_valid[d]), 32'd0);
    check_val({tag, "/idle_ready"}, 32'(req_ready[d]), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    logic [31:0] addr;
    int d;
    for (int i = 0; i < NDUT; i++) begin
      req_valid[i] = 1'b0; req_we[i] = 1'b0; req_addr[i] = 32'h0; req_wdata[i] = 32'h0;
      req_size[i] = 2'b00; req_unsigned[i] = 1'b0; rsp_ready[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < NDUT; i++) begin
      check_val("reset/req_ready", 32'(req_ready[i]), 32'd1);
      check_val("reset/rsp_valid", 32'(rsp_valid[i]), 32'd0);
      check_val("reset/rsp_rdata", rsp_rdata[i], 32'h0);
      check_val("reset/rsp_err", 32'(rsp_err[i]), 32'd0);
    end
    rst_n = 1'b1;

    for (int i = 0; i < NDUT; i++)
      for (int w = 0; w < DEPTH; w++)
        txn(i, 1'b1, 32'(w * 4), $urandom, 2'd2, 1'b0, 0, "fill", got);

    // Directed loads and stores on the single-wait-state responder.
    txn(1, 1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0, 0, "sw10", got);
    txn(1, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 0, "lw10", got);
    check_val("lw10_const", got, 32'hDEADBEEF);
    txn(1, 1'b1, 32'h20, 32'h80FF7F01, 2'd2, 1'b0, 0, "sw20", got);
    txn(1, 1'b0, 32'h23, 32'h0, 2'd0, 1'b0, 0, "lb23", got);
    check_val("lb23_const", got, 32'hFFFFFF80);
    txn(1, 1'b0, 32'h23, 32'h0, 2'd0, 1'b1, 0, "lbu23", got);
    check_val("lbu23_const", got, 32'h00000080);
    txn(1, 1'b0, 32'h22, 32'h0, 2'd1, 1'b0, 0, "lh22", got);
    check_val("lh22_const", got, 32'hFFFF80FF);
    txn(1, 1'b0, 32'h20, 32'h0, 2'd1, 1'b1, 0, "lhu20", got);
    check_val("lhu20_const", got, 32'h00007F01);
    txn(1, 1'b1, 32'h30, 32'h11223344, 2'd2, 1'b0, 0, "sw30", got);
    txn(1, 1'b1, 32'h31, 32'h000000AB, 2'd0, 1'b0, 0, "sb31", got);
    txn(1, 1'b0, 32'h30, 32'h0, 2'd2, 1'b0, 0, "lw30a", got);
    check_val("lw30a_const", got, 32'h1122AB44);
    txn(1, 1'b1, 32'h32, 32'h0000CAFE, 2'd1, 1'b0, 0, "sh32", got);
    txn(1, 1'b0, 32'h30, 32'h0, 2'd2, 1'b0, 0, "lw30b", got);
    check_val("lw30b_const", got, 32'hCAFEAB44);

    // Faulting accesses, each followed by a read-back of the untouched word.
    txn(1, 1'b1, 32'h40, 32'h5A5A5A5A, 2'd2, 1'b0, 0, "sw40", got);
    txn(1, 1'b0, 32'h42, 32'h0, 2'd2, 1'b0, 0, "err_lw42", got);
    txn(1, 1'b1, 32'h41, 32'hFFFF, 2'd1, 1'b0, 0, "err_sh41", got);
    txn(1, 1'b0, 32'h41, 32'h0, 2'd1, 1'b0, 0, "err_lh41", got);
    txn(1, 1'b1, 32'h40, 32'hFFFFFFFF, 2'd3, 1'b0, 0, "err_sz3", got);
    txn(1, 1'b0, 32'h40, 32'h0, 2'd2, 1'b0, 0, "lw40", got);
    check_val("lw40_const", got, 32'h5A5A5A5A);
    txn(1, 1'b1, 32'(DEPTH * 4), 32'h0BADF00D, 2'd2, 1'b0, 0, "err_sw_oor", got);
    txn(1, 1'b0, 32'h0, 32'h0, 2'd2, 1'b0, 0, "lw0", got);

    // Back-pressure on the zero- and three-wait-state responders.
    txn(0, 1'b1, 32'h44, 32'hA5A55A5A, 2'd2, 1'b0, 5, "hold0_sw", got);
    txn(0, 1'b0, 32'h44, 32'h0, 2'd2, 1'b0, 5, "hold0_lw", got);
    txn(2, 1'b1, 32'h48, 32'h01234567, 2'd2, 1'b0, 5, "hold3_sw", got);
    txn(2, 1'b0, 32'h4A, 32'h0, 2'd1, 1'b0, 5, "hold3_lh", got);

    // Reset while a store waits: the store must vanish.
    @(negedge clk);
    req_we[2] = 1'b1; req_addr[2] = 32'h50; req_wdata[2] = 32'h12345678;
    req_size[2] = 2'd2; req_unsigned[2] = 1'b0; req_valid[2] = 1'b1;
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    @(negedge clk);
    check_val("rstw/in_wait", 32'(req_ready[2]), 32'd0);
    rst_n = 1'b0;
    #1;
    check_val("rstw/req_ready", 32'(req_ready[2]), 32'd1);
    check_val("rstw/rsp_valid", 32'(rsp_valid[2]), 32'd0);
    check_val("rstw/rsp_err", 32'(rsp_err[2]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    txn(2, 1'b0, 32'h50, 32'h0, 2'd2, 1'b0, 0, "rstw_lw50", got);

    for (int k = 0; k < 200; k++) begin
      d = int'($urandom_range(0, NDUT - 1));
      if ($urandom % 8 == 0) addr = $urandom;
      else addr = 32'($urandom_range(0, DEPTH * 4 + 15));
      txn(d, 1'($urandom), addr, $urandom, 2'($urandom), 1'($urandom),
          int'($urandom_range(0, 2)), "rand", got);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
